// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared FSM state type and fetch defaults
`ifndef WORD
`define WORD 64
`endif
package fetch_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
    localparam int PC_STEP_DEF = 4;
endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// fetch_sequencer_pc_next: next-PC select between hold, increment and aligned redirect
`ifndef WORD
`define WORD 64
`endif
module fetch_sequencer_pc_next
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_STEP = PC_STEP_DEF
) (
    input  logic [`WORD-1:0] pc,
    input  logic             advance,
    input  logic             branch_taken,
    input  logic [`WORD-1:0] branch_target,
    output logic [`WORD-1:0] next_pc
);
    assign next_pc = branch_taken ? (branch_target & ~`WORD'(3)) :
                     advance      ? pc + `WORD'(PC_STEP) : pc;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch FSM with handshake, redirect, stall and fetch counter
`ifndef WORD
`define WORD 64
`endif
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [`WORD-1:0] RESET_PC = '0,
    parameter int               PC_STEP  = PC_STEP_DEF,
    parameter int               CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [`WORD-1:0] branch_target,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic [`WORD-1:0] imem_addr,
    output logic             fetch_valid,
    output logic [`WORD-1:0] fetch_pc,
    output logic [CNT_W-1:0] fetch_count
);
    state_t           state;
    logic [`WORD-1:0] pc;
    logic [`WORD-1:0] next_pc;
    logic             complete;
    assign imem_req  = state == REQ;
    assign imem_addr = pc;
    assign complete  = imem_req && imem_ready && !stall && !branch_taken;
    fetch_sequencer_pc_next #(.PC_STEP(PC_STEP)) u_pc_next (
        .pc(pc),
        .advance(complete),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .next_pc(next_pc)
    );
    // Out of IDLE the next state depends only on stall, redirect or not.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            fetch_valid <= 1'b0;
            fetch_pc    <= '0;
            fetch_count <= '0;
        end else begin
            state       <= (state != IDLE && stall) ? HOLD : REQ;
            pc          <= next_pc;
            fetch_valid <= complete;
            fetch_pc    <= complete ? pc : fetch_pc;
            fetch_count <= (complete && fetch_count != '1) ? fetch_count + CNT_W'(1) : fetch_count;
        end
    end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 4, byte increment per completed fetch.
REQ-003 Parameter CNT_W, default 32, width of fetch_count.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising clk edge only.
REQ-006 stall  input  1  downstream hold request; blocks fetch completion.
REQ-007 branch_taken  input  1  redirect request, one-cycle pulse.
REQ-008 branch_target  input  `WORD  redirect address.
REQ-009 imem_ready  input  1  instruction memory accepts/returns current request this cycle.
REQ-010 imem_req  output  1  request to instruction memory.
REQ-011 imem_addr  output  `WORD  address of current request; equals pc.
REQ-012 fetch_valid  output  1  registered; high one cycle per completed fetch.
REQ-013 fetch_pc  output  `WORD  registered PC of the completed fetch.
REQ-014 fetch_count  output  CNT_W  completed-fetch counter.

Function
REQ-015 FSM states: IDLE, REQ, HOLD; encoding unconstrained.
REQ-016 IDLE: imem_req=0; unconditionally -> REQ next cycle (single start-up bubble).
REQ-017 REQ: imem_req=1, imem_addr=pc.
REQ-018 Handshake completes in REQ when imem_ready=1 and stall=0 and branch_taken=0: pc <= pc+PC_STEP; next cycle fetch_valid=1, fetch_pc=old pc; stay REQ.
REQ-019 REQ with stall=1 (no branch) -> HOLD; pc unchanged; imem_ready ignored; fetch_valid=0 next cycle.
REQ-020 REQ with stall=0, imem_ready=0: pc unchanged, stay REQ, fetch_valid=0 next cycle.
REQ-021 HOLD: imem_req=0; stall=0 -> REQ next cycle; stall=1 -> remain HOLD.
REQ-022 branch_taken=1 has priority over all other events in any non-reset state: pc <= branch_target with low two bits forced to 0; in-flight request dropped (fetch_valid=0 next cycle even if imem_ready=1).
REQ-023 Next state on redirect: HOLD if stall=1, else REQ; in IDLE, redirect applies and state still -> REQ.
REQ-024 pc arithmetic modulo 2^`WORD: pc=64'hFFFF_FFFF_FFFF_FFFC completes -> pc=0, no flag.
REQ-025 fetch_count increments by 1 per completed fetch; saturates at all-ones, never wraps.
REQ-026 Throughput: with imem_ready=1, stall=0, one fetch_valid per cycle after start-up bubble.
REQ-027 imem_req, imem_addr combinational from state and pc only (no input-to-output path).

Reset
REQ-028 reset=0 at rising edge: state=IDLE, pc=RESET_PC, fetch_valid=0, fetch_pc=0, fetch_count=0; imem_req=0 the following cycle.
REQ-029 Reset overrides branch_taken, stall and an in-progress handshake; completing fetch is discarded, not counted.
REQ-030 Asserting reset between clock edges has no effect until next rising edge.

Structure
REQ-031 FSM state enum typedef and PC_STEP default go in shared fetch package; `WORD width macro reused from existing definitions.
REQ-032 One sub-module natural: pc_next (combinational next-PC select: hold / increment / aligned redirect); FSM and counters stay in fetch_sequencer.

Verification
REQ-033 Reset low 2 cycles, release, imem_ready=1, stall=0 -> cycle 1 imem_req=1 addr 0; fetch_pc 0,4,8 on consecutive cycles; fetch_count=3.
REQ-034 Steady fetch at pc=0x10, stall=1 for 3 cycles -> imem_req=0, pc stays 0x10, no fetch_valid; stall=0 -> next fetch_pc=0x10.
REQ-035 branch_taken with target 0x1003 while imem_ready=1 at pc=0x20 -> fetch_valid=0 next cycle, imem_addr=0x1000, then fetch_pc=0x1000.
REQ-036 Redirect to 64'hFFFF_FFFF_FFFF_FFFC, two completes -> fetch_pc ...FFFC then 0.
REQ-037 reset=0 coincident with imem_ready=1 and branch_taken=1 -> next cycle state IDLE, pc=RESET_PC, fetch_valid=0, fetch_count=0.
REQ-038 CNT_W=4, 20 completes -> fetch_count holds 15.
